acc_shifter_mx_array: RTL and testbench

Parametrised bit-serial activation streamer, the next generation of the accumulator shifter cell. It reads a contiguous run of DATA_W-bit words from a single-port SRAM and drives N_CH bit-serial channels, LSB first, with per-channel word selection. Each channel can output the current word, zero, its left neighbour or its right neighbour, with zero padding at row edges. A global stall input adds backpressure. The block sits between the activation SRAM and the bit-serial MAC columns.

---
 rtl/acc_shifter_mx_array.sv | 208 ++++++++++++++++++++
 tb/tb_acc_shifter_mx_array.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_shifter_mx_array.sv
`default_nettype none
// ============================================================================
// Module   : acc_shifter_mx_array
// Brief    : SRAM-fed bit-serial activation streamer with per-channel
//            KEEP/ZERO/LEFT/RIGHT word selection and row-edge zero padding.
// Revision : 1.0
// ============================================================================
module acc_shifter_mx_array #(
    parameter int N_CH       = 32,
    parameter int DATA_W     = 32,
    parameter int SRAM_DEPTH = 1024,
    parameter int ADDR_W     = $clog2(SRAM_DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                sram_en,
    output logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_data,
    input  logic                shift_start,
    output logic                shift_idle,
    input  logic                shift_stall,
    input  logic [2*N_CH-1:0]   shift_ctrl,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   img_size,
    input  logic [ADDR_W-1:0]   img_w,
    output logic [N_CH-1:0]     serial_output,
    output logic [N_CH-1:0]     serial_en,
    output logic [N_CH-1:0]     serial_start
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME0 = 2'd1;
    localparam logic [1:0] S_PRIME1 = 2'd2;
    localparam logic [1:0] S_SHIFT  = 2'd3;

    localparam logic [1:0] M_KEEP  = 2'd0;
    localparam logic [1:0] M_ZERO  = 2'd1;
    localparam logic [1:0] M_LEFT  = 2'd2;
    localparam logic [1:0] M_RIGHT = 2'd3;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic [1:0]         state_q, state_d;
    logic [2*N_CH-1:0]  ctrl_q;
    logic [ADDR_W-1:0]  base_q, size_q, imgw_q;
    logic [ADDR_W-1:0]  idx_q, col_q;
    logic [BIT_W-1:0]   bit_q;
    logic [DATA_W-1:0]  prev_q, cur_q, next_q, fbuf_q;
    logic               prime_q, rd_pend_q, fvalid_q;
    logic [N_CH-1:0]    sout_q, sen_q, sstart_q;

    logic               w_run, w_last_bit, w_advance, w_last_word;
    logic               w_pf_ok, w_pf, w_left_edge, w_right_edge;
    logic               w_rd_en;
    logic [ADDR_W-1:0]  w_rd_off;
    logic [DATA_W-1:0]  w_next, w_fetch;
    logic [N_CH-1:0]    w_bit;

    // Idle only once the final bit has left the output register.
    assign shift_idle   = (state_q == S_IDLE) && !sen_q[0];
    assign w_run        = (state_q == S_SHIFT) && !shift_stall;
    assign w_last_bit   = (bit_q == LAST_BIT);
    assign w_advance    = w_run && w_last_bit;
    assign w_last_word  = (idx_q == size_q);
    assign w_pf_ok      = ({1'b0, idx_q} + (ADDR_W+1)'(2)) <= {1'b0, size_q};
    assign w_pf         = w_run && (bit_q == '0) && w_pf_ok;
    assign w_left_edge  = (imgw_q == '0) ? (idx_q == '0) : (col_q == '0);
    assign w_right_edge = w_last_word || ((imgw_q != '0) && (col_q == imgw_q - ADDR_W'(1)));

    // Word 1 is still on the read bus during the first shift cycle.
    assign w_next  = prime_q ? (rd_pend_q ? sram_data : '0) : next_q;
    assign w_fetch = rd_pend_q ? sram_data : fbuf_q;

    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_off = '0;
        case (state_q)
            S_PRIME0: begin
                w_rd_en  = 1'b1;
                w_rd_off = '0;
            end
            S_PRIME1: begin
                w_rd_en  = (size_q != '0);
                w_rd_off = ADDR_W'(1);
            end
            S_SHIFT: begin
                w_rd_en  = w_pf;
                w_rd_off = idx_q + ADDR_W'(2);
            end
            default: begin
                w_rd_en  = 1'b0;
                w_rd_off = '0;
            end
        endcase
    end

    assign sram_en   = w_rd_en;
    assign sram_addr = w_rd_en ? (base_q + w_rd_off) : '0;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [1:0]        w_mode;
        logic [DATA_W-1:0] w_sel;

        assign w_mode = ctrl_q[2*ch +: 2];

        always_comb begin
            w_sel = '0;
            case (w_mode)
                M_KEEP:  w_sel = cur_q;
                M_ZERO:  w_sel = '0;
                M_LEFT:  w_sel = w_left_edge  ? '0 : prev_q;
                M_RIGHT: w_sel = w_right_edge ? '0 : w_next;
                default: w_sel = '0;
            endcase
        end

        assign w_bit[ch] = w_sel[bit_q];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (shift_start && shift_idle) state_d = S_PRIME0;
            S_PRIME0: state_d = S_PRIME1;
            S_PRIME1: state_d = S_SHIFT;
            S_SHIFT:  if (w_advance && w_last_word) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            base_q    <= '0;
            size_q    <= '0;
            imgw_q    <= '0;
            idx_q     <= '0;
            col_q     <= '0;
            bit_q     <= '0;
            prev_q    <= '0;
            cur_q     <= '0;
            next_q    <= '0;
            fbuf_q    <= '0;
            prime_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            fvalid_q  <= 1'b0;
            sout_q    <= '0;
            sen_q     <= '0;
            sstart_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= w_rd_en;
            if (rd_pend_q) fbuf_q <= sram_data;

            sen_q    <= {N_CH{w_run}};
            sstart_q <= {N_CH{w_run && (bit_q == '0)}};
            sout_q   <= w_run ? w_bit : '0;

            if ((state_q == S_IDLE) && (state_d == S_PRIME0)) begin
                ctrl_q   <= shift_ctrl;
                base_q   <= start_addr;
                size_q   <= img_size;
                imgw_q   <= img_w;
                idx_q    <= '0;
                col_q    <= '0;
                bit_q    <= '0;
                fvalid_q <= 1'b0;
            end

            if (state_q == S_PRIME1) begin
                prev_q  <= '0;
                cur_q   <= sram_data;
                prime_q <= 1'b1;
            end

            if (state_q == S_SHIFT) begin
                prime_q <= 1'b0;
                if (prime_q) next_q <= w_next;
                if (w_pf) fvalid_q <= 1'b1;
                if (w_run) begin
                    if (w_last_bit) begin
                        bit_q    <= '0;
                        prev_q   <= cur_q;
                        cur_q    <= w_next;
                        next_q   <= fvalid_q ? w_fetch : '0;
                        fvalid_q <= 1'b0;
                        idx_q    <= idx_q + ADDR_W'(1);
                        if ((imgw_q != '0) && (col_q == imgw_q - ADDR_W'(1)))
                            col_q <= '0;
                        else
                            col_q <= col_q + ADDR_W'(1);
                    end else begin
                        bit_q <= bit_q + BIT_W'(1);
                    end
                end
            end
        end
    end

    assign serial_output = sout_q;
    assign serial_en     = sen_q;
    assign serial_start  = sstart_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_shifter_mx_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_shifter_mx_array
// Brief    : Scoreboard bench for acc_shifter_mx_array.
// Revision : 1.0
// ============================================================================
module tb_acc_shifter_mx_array;

    localparam int N_CH       = 32;
    localparam int DATA_W     = 32;
    localparam int SRAM_DEPTH = 1024;
    localparam int ADDR_W     = 10;
    localparam int VEC_W      = N_CH * DATA_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [VEC_W-1:0]  vec_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                sram_en;
    logic [ADDR_W-1:0]   sram_addr;
    logic [DATA_W-1:0]   sram_data;
    logic                shift_start = 1'b0;
    logic                shift_idle;
    logic                shift_stall = 1'b0;
    logic [2*N_CH-1:0]   shift_ctrl = '0;
    logic [ADDR_W-1:0]   start_addr = '0;
    logic [ADDR_W-1:0]   img_size = '0;
    logic [ADDR_W-1:0]   img_w = '0;
    logic [N_CH-1:0]     serial_output;
    logic [N_CH-1:0]     serial_en;
    logic [N_CH-1:0]     serial_start;

    logic [DATA_W-1:0]   mem [0:SRAM_DEPTH-1];

    int   n_cmp = 0;
    int   n_err = 0;
    int   bitcnt = 0;
    int   word_cnt = 0;
    int   rd_idx = 0;
    bit   stall_prev = 1'b0;
    vec_t mon_vec;
    vec_t exp_vec;
    vec_t exp_q [$];
    addr_t addr_q [$];

    acc_shifter_mx_array #(
        .N_CH(N_CH), .DATA_W(DATA_W), .SRAM_DEPTH(SRAM_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .sram_en(sram_en), .sram_addr(sram_addr), .sram_data(sram_data),
        .shift_start(shift_start), .shift_idle(shift_idle), .shift_stall(shift_stall),
        .shift_ctrl(shift_ctrl), .start_addr(start_addr), .img_size(img_size), .img_w(img_w),
        .serial_output(serial_output), .serial_en(serial_en), .serial_start(serial_start)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM; garbage on the bus whenever no read was issued.
    always @(posedge clk) sram_data <= sram_en ? mem[sram_addr] : DATA_W'($urandom);

    // Expected word for every channel, built straight from the memory image.
    function automatic vec_t model_vec(addr_t sa, addr_t sz, addr_t w, logic [2*N_CH-1:0] ctrl, int i);
        vec_t v;
        logic [DATA_W-1:0] cw, pw, nw, word;
        int wi, si;
        bit le, re;
        wi = int'(w);
        si = int'(sz);
        cw = mem[addr_t'(sa + addr_t'(i))];
        pw = (i > 0)  ? mem[addr_t'(sa + addr_t'(i - 1))] : '0;
        nw = (i < si) ? mem[addr_t'(sa + addr_t'(i + 1))] : '0;
        le = (wi == 0) ? (i == 0) : ((i % wi) == 0);
        re = (i == si) || ((wi != 0) && ((i % wi) == wi - 1));
        v = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            case (ctrl[2*ch +: 2])
                2'd0:    word = cw;
                2'd1:    word = '0;
                2'd2:    word = le ? '0 : pw;
                default: word = re ? '0 : nw;
            endcase
            v[ch*DATA_W +: DATA_W] = word;
        end
        return v;
    endfunction

    function automatic void push_expect(addr_t sa, addr_t sz, addr_t w, logic [2*N_CH-1:0] ctrl);
        for (int i = 0; i <= int'(sz); i++) begin
            exp_q.push_back(model_vec(sa, sz, w, ctrl, i));
            addr_q.push_back(addr_t'(sa + addr_t'(i)));
        end
    endfunction

    // Monitor: deserialise lanes, pop the scoreboard, police reads and stalls.
    always @(negedge clk) begin
        if (!reset_n) begin
            bitcnt     = 0;
            stall_prev = 1'b0;
        end else begin
            if (shift_idle === 1'b1) rd_idx = 0;
            if (stall_prev) begin
                n_cmp++;
                if (serial_en !== '0) begin
                    n_err++;
                    $display("FAIL stall_en: serial_en=%h after stalled edge, required 0", serial_en);
                end
            end
            if (sram_en === 1'b1) begin
                n_cmp++;
                if (addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_read: sram_addr=%0d, required no read", sram_addr);
                end else begin
                    addr_t ea;
                    ea = addr_q.pop_front();
                    if (sram_addr !== ea) begin
                        n_err++;
                        $display("FAIL read_addr: sram_addr=%0d required %0d", sram_addr, ea);
                    end
                end
                if (rd_idx >= 2) begin
                    n_cmp++;
                    if (shift_stall) begin
                        n_err++;
                        $display("FAIL stall_read: sram_en=1 while stalled, required 0");
                    end
                end
                rd_idx++;
            end
            if (serial_en[0] === 1'b1) begin
                logic [N_CH-1:0] exp_st;
                exp_st = (bitcnt == 0) ? {N_CH{1'b1}} : '0;
                n_cmp++;
                if (serial_en !== {N_CH{1'b1}} || serial_start !== exp_st || shift_idle !== 1'b0) begin
                    n_err++;
                    $display("FAIL lane_ctl: en=%h start=%h idle=%b required en=all start=%h idle=0 (bit %0d)",
                             serial_en, serial_start, shift_idle, exp_st, bitcnt);
                end
                for (int ch = 0; ch < N_CH; ch++) mon_vec[ch*DATA_W + bitcnt] = serial_output[ch];
                bitcnt++;
                if (bitcnt == DATA_W) begin
                    bitcnt = 0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_word: word %0d delivered, required none", word_cnt);
                    end else begin
                        exp_vec = exp_q.pop_front();
                        if (mon_vec !== exp_vec) begin
                            int bad;
                            bad = 0;
                            for (int ch = N_CH - 1; ch >= 0; ch--)
                                if (mon_vec[ch*DATA_W +: DATA_W] !== exp_vec[ch*DATA_W +: DATA_W]) bad = ch;
                            n_err++;
                            $display("FAIL word %0d ch %0d: got %h required %h", word_cnt, bad,
                                     mon_vec[bad*DATA_W +: DATA_W], exp_vec[bad*DATA_W +: DATA_W]);
                        end
                    end
                    word_cnt++;
                end
            end else if (serial_start !== '0) begin
                n_cmp++;
                n_err++;
                $display("FAIL start_no_en: serial_start=%h without serial_en", serial_start);
            end
            stall_prev = shift_stall;
        end
    end

    // Caller sits 2 time units after a rising edge, so streams chain back to back.
    task automatic run_stream(input addr_t sa, input addr_t sz, input addr_t w,
                              input logic [2*N_CH-1:0] ctrl, input bit stall_en, input bit busy);
        int cyc, budget, w0;
        push_expect(sa, sz, w, ctrl);
        w0 = word_cnt;
        shift_ctrl  = ctrl;
        start_addr  = sa;
        img_size    = sz;
        img_w       = w;
        shift_start = 1'b1;
        @(posedge clk); #2;
        shift_start = 1'b0;
        shift_ctrl  = {$urandom, $urandom};
        start_addr  = addr_t'($urandom);
        img_size    = addr_t'($urandom);
        img_w       = addr_t'($urandom);
        n_cmp++;
        if (shift_idle !== 1'b0) begin
            n_err++;
            $display("FAIL start_busy: shift_idle=%b required 0", shift_idle);
        end
        budget = (int'(sz) + 1) * DATA_W * 4 + 40;
        cyc = 0;
        while (shift_idle !== 1'b1 && cyc < budget) begin
            shift_stall = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            shift_start = busy && (cyc == 40);
            @(posedge clk); #2;
            cyc++;
        end
        shift_stall = 1'b0;
        shift_start = 1'b0;
        n_cmp++;
        if (cyc >= budget) begin
            n_err++;
            $display("FAIL timeout: idle not seen in %0d cycles", budget);
        end
        if (!stall_en) begin
            n_cmp++;
            if (cyc != (int'(sz) + 1) * DATA_W + 3) begin
                n_err++;
                $display("FAIL latency: idle after %0d cycles required %0d", cyc, (int'(sz) + 1) * DATA_W + 3);
            end
        end
        n_cmp++;
        if (word_cnt - w0 != int'(sz) + 1) begin
            n_err++;
            $display("FAIL word_count: got %0d required %0d", word_cnt - w0, int'(sz) + 1);
        end
        n_cmp++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            n_err++;
            $display("FAIL leftovers: words=%0d reads=%0d required 0/0", exp_q.size(), addr_q.size());
        end
        exp_q.delete();
        addr_q.delete();
    endtask

    function automatic logic [2*N_CH-1:0] rand_ctrl(input bit keep_zero_only);
        logic [2*N_CH-1:0] c;
        for (int ch = 0; ch < N_CH; ch++)
            c[2*ch +: 2] = keep_zero_only ? {1'b0, 1'($urandom_range(0, 1))} : 2'($urandom_range(0, 3));
        return c;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (serial_output !== '0 || serial_en !== '0 || serial_start !== '0) begin
            n_err++;
            $display("FAIL reset_serial: out=%h en=%h start=%h required 0", serial_output, serial_en, serial_start);
        end
        n_cmp++;
        if (sram_en !== 1'b0 || sram_addr !== '0) begin
            n_err++;
            $display("FAIL reset_sram: en=%b addr=%0d required 0/0", sram_en, sram_addr);
        end
        n_cmp++;
        if (shift_idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: shift_idle=%b required 1", shift_idle);
        end
        reset_n = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if (shift_idle !== 1'b1 || sram_en !== 1'b0 || serial_en !== '0) begin
            n_err++;
            $display("FAIL post_reset: idle=%b sram_en=%b en=%h required 1/0/0", shift_idle, sram_en, serial_en);
        end
    endtask

    task automatic test_keep_zero(input logic [2*N_CH-1:0] ctrl, input bit stall_en);
        for (int k = 0; k < SRAM_DEPTH; k++) mem[k] = DATA_W'(k);
        run_stream(addr_t'(0), addr_t'(31), addr_t'(0), ctrl, stall_en, 1'b0);
    endtask

    task automatic test_left_right();
        logic [2*N_CH-1:0] c;
        c = rand_ctrl(1'b0);
        c[1:0] = 2'd2;
        c[3:2] = 2'd3;
        c[5:4] = 2'd0;
        c[7:6] = 2'd1;
        for (int k = 0; k < SRAM_DEPTH; k++) mem[k] = DATA_W'(k + 100);
        run_stream(addr_t'(0), addr_t'(11), addr_t'(4), c, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < SRAM_DEPTH; k++) mem[k] = $urandom;
        run_stream(addr_t'(200), addr_t'(6), addr_t'(3), rand_ctrl(1'b0), 1'b0, 1'b0);
        run_stream(addr_t'(17), addr_t'(1), addr_t'(0), rand_ctrl(1'b0), 1'b0, 1'b0);
    endtask

    task automatic test_single_word();
        logic [2*N_CH-1:0] c;
        c = rand_ctrl(1'b0);
        c[1:0] = 2'd0;
        c[3:2] = 2'd2;
        c[5:4] = 2'd3;
        mem[5] = 32'hDEADBEEF;
        run_stream(addr_t'(5), addr_t'(0), addr_t'(0), c, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_busy();
        for (int k = 0; k < SRAM_DEPTH; k++) mem[k] = $urandom;
        run_stream(addr_t'(SRAM_DEPTH - 2), addr_t'(3), addr_t'(2), rand_ctrl(1'b0), 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [2*N_CH-1:0] c;
        int cyc;
        c = rand_ctrl(1'b0);
        for (int k = 0; k < SRAM_DEPTH; k++) mem[k] = DATA_W'(k);
        push_expect(addr_t'(0), addr_t'(7), addr_t'(4), c);
        word_cnt = 0;
        shift_ctrl  = c;
        start_addr  = '0;
        img_size    = addr_t'(7);
        img_w       = addr_t'(4);
        shift_start = 1'b1;
        @(posedge clk); #2;
        shift_start = 1'b0;
        cyc = 0;
        while (!(word_cnt == 3 && bitcnt == 10) && cyc < 1000) begin
            @(negedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (cyc >= 1000) begin
            n_err++;
            $display("FAIL reset_mid_reach: word 3 bit 10 not reached (word %0d bit %0d)", word_cnt, bitcnt);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (serial_output !== '0 || serial_en !== '0 || serial_start !== '0 ||
            sram_en !== 1'b0 || sram_addr !== '0 || shift_idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: out=%h en=%h st=%h sram_en=%b addr=%0d idle=%b required 0s and idle=1",
                     serial_output, serial_en, serial_start, sram_en, sram_addr, shift_idle);
        end
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (sram_en !== 1'b0 || shift_idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold: sram_en=%b idle=%b required 0/1", sram_en, shift_idle);
        end
        reset_n = 1'b1;
        @(posedge clk); #2;
        run_stream(addr_t'(0), addr_t'(7), addr_t'(4), c, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2*N_CH-1:0] ramp_ctrl;
        ramp_ctrl = rand_ctrl(1'b1);
        ramp_ctrl[1:0] = 2'd0;
        ramp_ctrl[3:2] = 2'd1;
        test_reset();
        test_keep_zero(ramp_ctrl, 1'b0);
        test_left_right();
        test_back_to_back();
        test_keep_zero(ramp_ctrl, 1'b1);
        test_single_word();
        test_wrap_busy();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
